// File: rtl/alu_arbiter.sv
// Two-client arbiter in front of a single shared adder/subtractor.
// One operation in flight at a time (IDLE -> EXEC -> RESP), round-robin on ties.

// Combinational N-bit adder/subtractor: select=0 -> a+b, select=1 -> a+~b+1.
module arithmetic_unit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         select,
    output logic [N-1:0] out,
    output logic         cout
);
    logic [N-1:0] b_eff;

    assign b_eff       = select ? ~b : b;
    assign {cout, out} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, select};
endmodule

module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_result,
    output logic         rsp0_cout,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_result,
    output logic         rsp1_cout,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_q, last_d;      // requester served most recently
    logic         owner_q, owner_d;    // requester of the operation in flight
    logic [N-1:0] opa_q, opa_d;
    logic [N-1:0] opb_q, opb_d;
    logic         opsel_q, opsel_d;

    logic [1:0]   rsp_valid_q;
    logic [N-1:0] rsp_result_q [2];
    logic [1:0]   rsp_cout_q;
    logic [1:0]   rsp_ready_vec;

    logic         winner;
    logic         accept;
    logic         rsp_hs;
    logic [N-1:0] alu_out;
    logic         alu_cout;

    // Round-robin winner: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // A valid request is always accepted in IDLE; never while reset is asserted.
    assign accept     = (state_q == S_IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;

    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
    assign rsp_hs        = (state_q == S_RESP) && rsp_valid_q[owner_q] && rsp_ready_vec[owner_q];

    // Operands reach the shared unit only from registers.
    arithmetic_unit #(.N(N)) u_alu (
        .a      (opa_q),
        .b      (opb_q),
        .select (opsel_q),
        .out    (alu_out),
        .cout   (alu_cout)
    );

    // Next-state and operand-capture logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opsel_d = opsel_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d = winner;
                    last_d  = winner;
                    opa_d   = winner ? req1_a  : req0_a;
                    opb_d   = winner ? req1_b  : req0_b;
                    opsel_d = winner ? req1_op : req0_op;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and operand registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            opsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opsel_q <= opsel_d;
        end
    end

    // Per-requester response registers: captured in EXEC by the owner, cleared on handshake.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        localparam logic IDX = 1'(gi);

        // Response capture / valid clear for requester gi.
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_valid_q[gi]  <= 1'b0;
                rsp_result_q[gi] <= '0;
                rsp_cout_q[gi]   <= 1'b0;
            end else if (state_q == S_EXEC && owner_q == IDX) begin
                rsp_valid_q[gi]  <= 1'b1;
                rsp_result_q[gi] <= alu_out;
                rsp_cout_q[gi]   <= alu_cout;
            end else if (rsp_hs && owner_q == IDX) begin
                rsp_valid_q[gi]  <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp0_result = rsp_result_q[0];
    assign rsp0_cout   = rsp_cout_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp1_result = rsp_result_q[1];
    assign rsp1_cout   = rsp_cout_q[1];
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N=4): a table of single operations plus
// hand-written sequences for arbitration, backpressure, reset and sampling.
module tb_alu_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_op;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_op;
    logic [N-1:0] req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp0_cout;
    logic [N-1:0] rsp0_result;
    logic         rsp1_valid, rsp1_ready, rsp1_cout;
    logic [N-1:0] rsp1_result;
    logic         busy;

    int n_vec  = 0;
    int n_fail = 0;

    alu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_cout   (rsp0_cout),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_cout   (rsp1_cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         who;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         op;
        logic [N-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    // One accept/execute/respond transaction from a single requester.
    task automatic run_vec(input int idx, input vec_t v);
        logic [N-1:0] res;
        logic         co, rv, orv;
        if (v.who == 1'b0) begin
            req0_valid = 1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end else begin
            req1_valid = 1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end
        #1;
        chk($sformatf("v%0d ready", idx), v.who ? req1_ready : req0_ready, 1);
        chk($sformatf("v%0d other_ready", idx), v.who ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        chk($sformatf("v%0d busy_exec", idx), busy, 1);
        chk($sformatf("v%0d rsp_early", idx), {rsp1_valid, rsp0_valid}, 0);
        tick();
        rv  = v.who ? rsp1_valid  : rsp0_valid;
        orv = v.who ? rsp0_valid  : rsp1_valid;
        res = v.who ? rsp1_result : rsp0_result;
        co  = v.who ? rsp1_cout   : rsp0_cout;
        chk($sformatf("v%0d rsp_valid", idx), rv, 1);
        chk($sformatf("v%0d other_rsp_valid", idx), orv, 0);
        chk($sformatf("v%0d result", idx), res, v.exp_res);
        chk($sformatf("v%0d cout", idx), co, v.exp_cout);
        $display("vec %0d: req%0d a=%0h b=%0h op=%0d -> result=%0h cout=%0d (expected %0h/%0d)",
                 idx, v.who, v.a, v.b, v.op, res, co, v.exp_res, v.exp_cout);
        tick();
        chk($sformatf("v%0d rsp_drop", idx), {rsp1_valid, rsp0_valid}, 0);
        chk($sformatf("v%0d busy_idle", idx), busy, 0);
    endtask

    int acc_cyc [3];
    int acc_who [3];
    int n_acc;

    initial begin
        vecs[0] = '{1'b0, 4'd7,  4'd9,  1'b0, 4'h0, 1'b1};
        vecs[1] = '{1'b1, 4'd3,  4'd5,  1'b1, 4'hE, 1'b0};
        vecs[2] = '{1'b1, 4'd5,  4'd3,  1'b1, 4'h2, 1'b1};
        vecs[3] = '{1'b0, 4'd15, 4'd1,  1'b0, 4'h0, 1'b1};
        vecs[4] = '{1'b0, 4'd4,  4'd3,  1'b0, 4'h7, 1'b0};
        vecs[5] = '{1'b1, 4'd0,  4'd0,  1'b1, 4'h0, 1'b1};
        vecs[6] = '{1'b0, 4'd0,  4'd1,  1'b1, 4'hF, 1'b0};
        vecs[7] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'hE, 1'b1};

        // Reset state.
        do_reset();
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst results", {rsp1_result, rsp0_result}, 0);
        chk("rst couts", {rsp1_cout, rsp0_cout}, 0);
        chk("rst ready_noreq", {req1_ready, req0_ready}, 0);

        // Table of single-requester operations.
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Tie arbitration: both held valid, order 0,1,0 at 3-cycle spacing.
        do_reset();
        req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 0;
        req1_valid = 1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 0;
        #1;
        n_acc = 0;
        for (int c = 0; c < 20 && n_acc < 3; c++) begin
            if (req0_ready || req1_ready) begin
                acc_cyc[n_acc] = c;
                acc_who[n_acc] = req1_ready ? 1 : 0;
                $display("tie: accept %0d by req%0d at cycle %0d", n_acc, acc_who[n_acc], c);
                n_acc++;
            end
            tick();
        end
        chk("tie accepts", n_acc, 3);
        if (n_acc == 3) begin
            chk("tie order0", acc_who[0], 0);
            chk("tie order1", acc_who[1], 1);
            chk("tie order2", acc_who[2], 0);
            chk("tie gap01", acc_cyc[1] - acc_cyc[0], 3);
            chk("tie gap12", acc_cyc[2] - acc_cyc[1], 3);
        end
        req0_valid = 0; req1_valid = 0;
        for (int c = 0; c < 3; c++) tick();
        chk("tie rsp0_result", rsp0_result, 2);
        chk("tie rsp1_result", rsp1_result, 4);

        // Backpressure on rsp0 while req1 waits.
        do_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 4'd6; req0_b = 4'd5; req0_op = 0;
        req1_valid = 1; req1_a = 4'd4; req1_b = 4'd1; req1_op = 1;
        #1;
        chk("bp req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        chk("bp req1_ready_exec", req1_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d rsp0_valid", i), rsp0_valid, 1);
            chk($sformatf("bp%0d rsp0_result", i), rsp0_result, 4'hB);
            chk($sformatf("bp%0d rsp0_cout", i), rsp0_cout, 0);
            chk($sformatf("bp%0d req1_ready", i), req1_ready, 0);
            tick();
        end
        rsp0_ready = 1;
        #1;
        chk("bp hs req1_ready", req1_ready, 0);
        chk("bp hs rsp0_valid", rsp0_valid, 1);
        tick();
        chk("bp after rsp0_valid", rsp0_valid, 0);
        chk("bp after req1_ready", req1_ready, 1);
        chk("bp hold rsp0_result", rsp0_result, 4'hB);
        $display("backpressure: rsp0 result=%0h held, req1 accepted after handshake", rsp0_result);
        tick();
        req1_valid = 0;
        tick();
        chk("bp rsp1_valid", rsp1_valid, 1);
        chk("bp rsp1_result", rsp1_result, 4'h3);
        chk("bp rsp1_cout", rsp1_cout, 1);
        tick();

        // Reset during EXEC: operation dropped, state cleared, next tie to req0.
        do_reset();
        req0_valid = 1; req0_a = 4'd9; req0_b = 4'd2; req0_op = 0;
        #1;
        chk("rm req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        chk("rm busy_exec", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rm busy", busy, 0);
        chk("rm rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rm results", {rsp1_result, rsp0_result}, 0);
        chk("rm couts", {rsp1_cout, rsp0_cout}, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rm no_rsp%0d", i), {rsp1_valid, rsp0_valid}, 0);
            tick();
        end
        rst = 1;
        req0_valid = 1;
        #1;
        chk("rm ready_in_rst", {req1_ready, req0_ready}, 0);
        tick();
        rst = 0;
        req0_a = 4'd1; req0_b = 4'd1; req0_op = 0;
        req1_valid = 1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 0;
        #1;
        chk("rm tie req0_ready", req0_ready, 1);
        chk("rm tie req1_ready", req1_ready, 0);
        $display("reset mid-op: dropped op, tie granted to req%0d", req1_ready ? 1 : 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        chk("rm tie rsp0_result", rsp0_result, 4'h2);
        tick();

        // Operand sampling: inputs changed after accept must not affect result.
        do_reset();
        req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3; req0_op = 0;
        #1;
        chk("os req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0; req0_a = 4'd15; req0_b = 4'd15; req0_op = 1;
        tick();
        chk("os rsp0_valid", rsp0_valid, 1);
        chk("os rsp0_result", rsp0_result, 4'h5);
        chk("os rsp0_cout", rsp0_cout, 0);
        $display("operand sampling: result=%0h cout=%0d", rsp0_result, rsp0_cout);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
